mod_reduce_seq: RTL

Bit-serial modular reduction stage that sits directly downstream of the combinational array multiplier `mul`. It captures the multiplier's (N+W')-bit product P together with a modulus M and computes R = P mod M by restoring shift-subtract, one product bit per clock. Input and output use valid/ready handshakes, so the stage can be placed between a registered multiplier output and the consumer of modular products.

---
 rtl/mod_reduce_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: bit-serial restoring reduction R = P mod M of a W-bit product.
// Latency: W edges after the accept edge (1 edge when M==0), then one handoff edge.
// Backpressure: in_ready is high only when idle; R/err/out_valid are held while out_ready is low.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid / in_ready   input handshake carrying P (W bits) and M (N bits)
//   out_valid / out_ready output handshake carrying R (N bits) and err
//   err                   set when M was 0; R is forced to 0 in that case
module mod_reduce_seq #(
  parameter int N = 7,
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] P,
  input  logic [N-1:0] M,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] R,
  output logic         err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  p_q;
  logic [N-1:0]  m_q;
  // The remainder stays below M after every iteration, so its top bit is
  // always zero and only the low N bits are kept between iterations.
  logic [N-1:0]  r_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [N-1:0]  res_q;
  logic          err_q;

  // One restoring step: shift the next product bit into the remainder and
  // subtract M when the widened value reaches it. t < 2M, so N+1 bits suffice.
  logic [N:0]   t_d;
  logic [N:0]   m_ext;
  logic [N-1:0] r_d;

  always_comb begin
    t_d   = {r_q, p_q[W-1]};
    m_ext = {1'b0, m_q};
    r_d   = N'((t_d >= m_ext) ? (t_d - m_ext) : t_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            p_q        <= P;
            m_q        <= M;
            r_q        <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end

        RUN: begin
          if (m_q == '0) begin
            // Zero modulus: no iterations, report the error one edge after accept.
            res_q       <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            r_q   <= r_d;
            p_q   <= p_q << 1;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              res_q       <= r_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign R         = res_q;
  assign err       = err_q;

endmodule
